// File: rtl/q_mul_seq.sv
// q_mul_seq: sequential signed fixed-point multiplier.
// Shift-add on operand magnitudes, one multiplier bit per cycle, with the
// product rescaled by FRAC and saturated to the signed WIDTH-bit range.

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef FRAC_BITS
`define FRAC_BITS 8
`endif

module q_mul_seq #(
    parameter int WIDTH = `FIXED_WIDTH,
    parameter int FRAC  = `FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             sat
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    // Saturation bounds as magnitudes (2*WIDTH wide) and as output codes.
    localparam logic [2*WIDTH-1:0] MAX_MAG   = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [2*WIDTH-1:0] MIN_MAG   = {{WIDTH{1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0]   FIXED_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0]   FIXED_MIN = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               sat_q, sat_d;

    logic [WIDTH-1:0]   absA, absB;
    logic [2*WIDTH-1:0] addend, accSum, mag;
    logic [WIDTH-1:0]   finRes;
    logic               finSat;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign sat       = sat_q;

    // Operand magnitudes; the most negative code maps to 2^(WIDTH-1), which fits unsigned.
    always_comb begin
        absA = a[WIDTH-1] ? -a : a;
        absB = b[WIDTH-1] ? -b : b;
    end

    // One shift-add step plus the rescale/saturate applied on the final iteration.
    always_comb begin
        addend = mplier_q[0] ? mcand_q : '0;
        accSum = acc_q + addend;
        mag    = accSum >> FRAC;
        finRes = '0;
        finSat = 1'b0;
        if (!sign_q && (mag > MAX_MAG)) begin
            finRes = FIXED_MAX;
            finSat = 1'b1;
        end else if (sign_q && (mag > MIN_MAG)) begin
            finRes = FIXED_MIN;
            finSat = 1'b1;
        end else begin
            finRes = sign_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
        end
    end

    // Next-state logic: accept in IDLE, iterate WIDTH times in BUSY, hold in DONE.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;
        sat_d    = sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, absA};
                    mplier_d = absB;
                    sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = accSum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    result_d = finRes;
                    sat_d    = finSat;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

endmodule

// File: tb/tb_q_mul_seq.sv
// tb_q_mul_seq: directed self-checking bench for q_mul_seq in Q8.8.

module tb_q_mul_seq;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    logic             clk;
    logic             rst_n;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic             sat;

    int checks = 0;
    int errors = 0;

    q_mul_seq #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inValid),
        .in_ready (inReady),
        .a        (opA),
        .b        (opB),
        .out_valid(outValid),
        .out_ready(outReady),
        .result   (result),
        .sat      (sat)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and reports tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present operands on a falling edge and hold them across one rising edge.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] va,
                                 input logic [WIDTH-1:0] vb);
        @(negedge clk);
        checkOutput({tag, "_in_ready_before_accept"}, inReady, 1'b1);
        inValid = 1'b1;
        opA     = va;
        opB     = vb;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        opA     = WIDTH'($urandom);
        opB     = WIDTH'($urandom);
    endtask

    // Count rising edges after the accept edge until out_valid, bounded.
    task automatic waitResult(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            opA = WIDTH'($urandom);
            opB = WIDTH'($urandom);
        end while (!outValid && cycles < 40);
        if (!outValid) begin
            checkOutput({tag, "_timeout"}, outValid, 1'b1);
        end
    endtask

    // Handshake the pending result and confirm the return to IDLE.
    task automatic consumeResult(input string tag);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput({tag, "_out_valid_after_take"}, outValid, 1'b0);
        checkOutput({tag, "_in_ready_after_take"}, inReady, 1'b1);
    endtask

    // Full directed transaction with latency, result and sat checks.
    task automatic runVector(input string tag, input logic [WIDTH-1:0] va,
                             input logic [WIDTH-1:0] vb,
                             input logic [WIDTH-1:0] expRes, input logic expSat);
        int cyc;
        applyStimulus(tag, va, vb);
        waitResult(tag, cyc);
        checkOutput({tag, "_latency"}, cyc, 16);
        checkOutput({tag, "_result"}, result, expRes);
        checkOutput({tag, "_sat"}, sat, expSat);
        checkOutput({tag, "_in_ready_in_done"}, inReady, 1'b0);
        consumeResult(tag);
    endtask

    // Directed sequence.
    initial begin
        int cyc;
        int firstHit;
        int secondHit;
        int seenValid;

        rst_n    = 1'b0;
        inValid  = 1'b1;
        outReady = 1'b0;
        opA      = 16'h0100;
        opB      = 16'h0100;

        // Power-on reset with in_valid asserted; it must be ignored.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", outValid, 1'b0);
        checkOutput("reset_result", result, 16'h0000);
        checkOutput("reset_sat", sat, 1'b0);
        inValid = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready_after_release", inReady, 1'b1);

        // Basic signed products and truncation toward zero.
        runVector("p1p5_x_2",   16'h0180, 16'h0200, 16'h0300, 1'b0);
        runVector("m1p5_x_2",   16'hFE80, 16'h0200, 16'hFD00, 1'b0);
        runVector("min_x_1",    16'h8000, 16'h0100, 16'h8000, 1'b0);
        runVector("pos_sat",    16'h6400, 16'h6400, 16'h7FFF, 1'b1);
        runVector("min_x_m1",   16'h8000, 16'hFF00, 16'h7FFF, 1'b1);
        runVector("neg_sat",    16'h6400, 16'h9C00, 16'h8000, 1'b1);
        runVector("tiny_pos",   16'h0001, 16'h0001, 16'h0000, 1'b0);
        runVector("tiny_neg",   16'hFFFF, 16'h0001, 16'h0000, 1'b0);

        // Backpressure: result held for 5 cycles, new operands refused meanwhile.
        applyStimulus("bp", 16'hFE80, 16'h0200);
        waitResult("bp", cyc);
        checkOutput("bp_latency", cyc, 16);
        inValid = 1'b1;
        opA     = 16'h0100;
        opB     = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_hold%0d_out_valid", i), outValid, 1'b1);
            checkOutput($sformatf("bp_hold%0d_result", i), result, 16'hFD00);
            checkOutput($sformatf("bp_hold%0d_sat", i), sat, 1'b0);
            checkOutput($sformatf("bp_hold%0d_in_ready", i), inReady, 1'b0);
        end
        inValid = 1'b0;
        consumeResult("bp");

        // Back-to-back throughput with out_ready and in_valid held high.
        @(negedge clk);
        outReady  = 1'b1;
        inValid   = 1'b1;
        opA       = 16'h0100;
        opB       = 16'h0200;
        firstHit  = -1;
        secondHit = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (outValid) begin
                checkOutput($sformatf("tput_result_at%0d", i), result, 16'h0200);
                checkOutput($sformatf("tput_in_ready_at%0d", i), inReady, 1'b0);
                if (firstHit < 0) begin
                    firstHit = i;
                end else begin
                    secondHit = i;
                    inValid   = 1'b0;
                    break;
                end
            end
        end
        checkOutput("tput_first_latency", firstHit, 17);
        checkOutput("tput_period", secondHit - firstHit, 18);
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("tput_idle_after", inReady, 1'b1);

        // Reset in the middle of BUSY with in_valid held; no stale result may surface.
        applyStimulus("rst", 16'h6400, 16'h6400);
        repeat (6) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", outValid, 1'b0);
        checkOutput("rst_result", result, 16'h0000);
        checkOutput("rst_sat", sat, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_out_valid", outValid, 1'b0);
        rst_n   = 1'b1;
        inValid = 1'b0;
        checkOutput("rst_in_ready_after_release", inReady, 1'b1);
        seenValid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (outValid) begin
                seenValid++;
            end
        end
        checkOutput("rst_no_stale_result", seenValid, 0);
        runVector("post_rst", 16'h0100, 16'h0100, 16'h0100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/q_mul_seq.md
# q_mul_seq

Sequential signed fixed-point multiplier that produces `a * b` in the same Q-format as the fixed-point divider, with the same saturation to `FIXED_MAX`/`FIXED_MIN`. It is the multiplicative counterpart of the divider.
- Area-cheap iterative shift-add: one multiplier bit per cycle.
- Operands in and results out each use a valid/ready handshake, so it drops into the same datapaths that feed the divider.

## Interface
Parameters:
- WIDTH, default `FIXED_WIDTH: total operand/result width, two's complement.
- FRAC, default `FRAC_BITS: fractional bits; must satisfy 0 <= FRAC < WIDTH.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  signed multiplicand.
- b  input  WIDTH  signed multiplier.
- out_valid  output  1  result/sat valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  signed saturated product.
- sat  output  1  result was clamped to `FIXED_MAX`/`FIXED_MIN`.

## Operation
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE:
  - On in_valid && in_ready, latch |a| and |b| as WIDTH-bit unsigned magnitudes. |FIXED_MIN| = 2^(WIDTH-1) is representable.
  - Latch sign = a[WIDTH-1] ^ b[WIDTH-1]; clear the 2*WIDTH-bit accumulator and the bit counter; go to BUSY.
- BUSY, each cycle:
  - If the multiplier LSB is 1, add the shifted multiplicand to the accumulator.
  - Shift the multiplicand left and the multiplier right; increment the counter.
- After WIDTH iterations, finalize and go to DONE:
  - mag = acc >> FRAC (truncate; magnitude rounds toward zero).
  - If sign==0 and mag > `FIXED_MAX`: result = `FIXED_MAX`, sat=1.
  - Else if sign==1 and mag > 2^(WIDTH-1): result = `FIXED_MIN`, sat=1.
  - Else result = sign ? -mag : mag (low WIDTH bits), sat=0.
  - Zero magnitude always yields result 0, regardless of sign.
- DONE: hold result and sat stable. On out_ready go to IDLE. No operand acceptance in DONE.
- Inputs a/b are ignored except on the accept cycle; they may change freely during BUSY.
- All intermediate arithmetic is unsigned on magnitudes. The accumulator is 2*WIDTH bits, so it never overflows internally.

## Timing
- Reset (rst_n low at a rising edge):
  - state=IDLE, out_valid=0, result=0, sat=0, accumulator and counter cleared.
  - in_ready=1 from the first cycle rst_n is high. While rst_n is low, in_valid is ignored.
- Reset mid-BUSY or mid-DONE: the operation is abandoned and no result is delivered. out_valid is 0 in the cycle after the reset edge.
- Latency: operands accepted at edge k; out_valid is high after edge k+WIDTH (WIDTH cycles in BUSY, DONE entered on edge k+WIDTH).
- Throughput, with out_ready held high: one result per WIDTH+2 cycles (accept, WIDTH BUSY cycles, DONE handshake, back in IDLE).
- Backpressure: out_valid stays high and result/sat stay unchanged until the out_ready handshake. in_ready stays 0 meanwhile.
- out_valid and in_ready are never high in the same cycle.
- No combinational path from in_valid/out_ready to any output.

## Test plan
Test configuration: WIDTH=16, FRAC=8 (Q8.8).
- a=0x0180 (1.5), b=0x0200 (2.0) -> result=0x0300, sat=0; out_valid rises exactly 16 cycles after the accept edge.
- a=0xFE80 (-1.5), b=0x0200 -> 0xFD00, sat=0. Separately, a=0x8000 (-128), b=0x0100 (1.0) -> 0x8000, sat=0.
- a=0x6400 (100), b=0x6400 -> 0x7FFF, sat=1. Separately, a=0x8000, b=0xFF00 (-1.0) -> 0x7FFF, sat=1. Separately, a=0x6400, b=0x9C00 (-100) -> 0x8000, sat=1.
- a=0x0001, b=0x0001 -> 0x0000. Separately, a=0xFFFF, b=0x0001 -> 0x0000 (truncation toward zero), sat=0.
- Hold out_ready=0 for 5 cycles after out_valid:
  - result/sat stay stable and in_ready stays 0.
  - Raise out_ready: out_valid drops next cycle and in_ready=1.
  - Back-to-back operands with out_ready=1: one result every 18 cycles.
- Assert rst_n=0 at BUSY cycle 7, with in_valid=1 held during reset:
  - Next cycle: out_valid=0, result=0, in_ready=1 after release.
  - No stale result appears; a fresh 0x0100*0x0100 then returns 0x0100.
